// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode interrupt trap sequencer.
package trap_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] CAUSE_TMR = 32'h8000_0007;
  localparam logic [XLEN-1:0] CAUSE_EXT = 32'h8000_000B;

  // Direct-mode vector: low two bits of mtvec are the mode field, not address.
  localparam logic [XLEN-1:0] VEC_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TAKE    = 3'd1,
    ST_REDIR   = 3'd2,
    ST_HANDLER = 3'd3,
    ST_RETURN  = 3'd4
  } trap_state_e;

endpackage

// File: rtl/trap_controller_irq_priority.sv
// Combinational interrupt cause encoder: timer wins over external.
module irq_priority
  import trap_pkg::*;
(
  input  logic            ext_irq_i,
  input  logic            tmr_irq_i,
  output logic            req_o,
  output logic [XLEN-1:0] cause_o
);

  // Any request plus its prioritised mcause encoding.
  always_comb begin
    req_o   = ext_irq_i | tmr_irq_i;
    cause_o = tmr_irq_i ? CAUSE_TMR : CAUSE_EXT;
  end

endmodule

// File: rtl/trap_controller.sv
// Interrupt entry/exit sequencer: CSR writes, pipeline flush and PC redirect.
module trap_controller
  import trap_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ext_irq,
  input  logic            tmr_irq,
  input  logic            mie_g,
  input  logic            valid_m,
  input  logic [XLEN-1:0] pc_m,
  input  logic            mret_e,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            int_flush,
  output logic            stall_f,
  output logic            redir_v,
  output logic [XLEN-1:0] redir_pc,
  output logic            mepc_we,
  output logic [XLEN-1:0] mepc_wd,
  output logic            mcause_we,
  output logic [XLEN-1:0] mcause_wd,
  output logic            mie_clr,
  output logic            mie_set,
  output logic            in_handler
);

  trap_state_e     state_q;
  logic [XLEN-1:0] held_pc_q;
  logic [XLEN-1:0] held_cause_q;
  logic            irq_req;
  logic [XLEN-1:0] irq_cause;
  logic            pend;

  irq_priority u_prio (
    .ext_irq_i (ext_irq),
    .tmr_irq_i (tmr_irq),
    .req_o     (irq_req),
    .cause_o   (irq_cause)
  );

  // Only a real instruction in memory stage can be the precise trap point.
  assign pend = irq_req & mie_g & valid_m;

  // Sequence state plus the PC/cause captured when the trap is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      held_pc_q    <= '0;
      held_cause_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pend) begin
            state_q      <= ST_TAKE;
            held_pc_q    <= pc_m;
            held_cause_q <= irq_cause;
          end
        end
        ST_TAKE:    state_q <= ST_REDIR;
        ST_REDIR:   state_q <= ST_HANDLER;
        ST_HANDLER: if (mret_e) state_q <= ST_RETURN;
        ST_RETURN:  state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  // Moore output decode; reset blanks everything in the same cycle.
  always_comb begin
    int_flush  = 1'b0;
    stall_f    = 1'b0;
    redir_v    = 1'b0;
    redir_pc   = '0;
    mepc_we    = 1'b0;
    mepc_wd    = '0;
    mcause_we  = 1'b0;
    mcause_wd  = '0;
    mie_clr    = 1'b0;
    mie_set    = 1'b0;
    in_handler = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_TAKE: begin
          int_flush = 1'b1;
          stall_f   = 1'b1;
          mepc_we   = 1'b1;
          mepc_wd   = held_pc_q;
          mcause_we = 1'b1;
          mcause_wd = held_cause_q;
          mie_clr   = 1'b1;
        end
        ST_REDIR: begin
          int_flush = 1'b1;
          redir_v   = 1'b1;
          redir_pc  = mtvec & VEC_MASK;
        end
        ST_HANDLER: in_handler = 1'b1;
        ST_RETURN: begin
          int_flush = 1'b1;
          redir_v   = 1'b1;
          redir_pc  = mepc;
          mie_set   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller against a behavioural trap model.
module tb_trap_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_irq, tmr_irq, mie_g, valid_m, mret_e;
  logic [31:0] pc_m, mtvec, mepc;
  logic        int_flush, stall_f, redir_v, mepc_we, mcause_we;
  logic        mie_clr, mie_set, in_handler;
  logic [31:0] redir_pc, mepc_wd, mcause_wd;

  int total = 0;
  int bad   = 0;

  // Model: what the current cycle is doing, whether the handler runs,
  // and the PC/cause remembered when the trap was accepted.
  localparam int M_NONE = 0, M_CSR = 1, M_VEC = 2, M_RET = 3;
  int          m_act;
  bit          m_hand;
  logic [31:0] m_pc, m_cause;

  always #5 clk = ~clk;

  trap_controller dut (
    .clk(clk), .rst(rst), .ext_irq(ext_irq), .tmr_irq(tmr_irq),
    .mie_g(mie_g), .valid_m(valid_m), .pc_m(pc_m), .mret_e(mret_e),
    .mtvec(mtvec), .mepc(mepc), .int_flush(int_flush), .stall_f(stall_f),
    .redir_v(redir_v), .redir_pc(redir_pc), .mepc_we(mepc_we),
    .mepc_wd(mepc_wd), .mcause_we(mcause_we), .mcause_wd(mcause_wd),
    .mie_clr(mie_clr), .mie_set(mie_set), .in_handler(in_handler)
  );

  function automatic logic [103:0] obs_vec();
    return {int_flush, stall_f, redir_v, mepc_we, mcause_we, mie_clr,
            mie_set, in_handler, redir_pc, mepc_wd, mcause_wd};
  endfunction

  // Expected outputs for the current cycle from the model and live CSR inputs.
  function automatic logic [103:0] exp_vec();
    logic [7:0]  f;
    logic [31:0] rp, ew, cw;
    f = '0; rp = '0; ew = '0; cw = '0;
    if (!rst) begin
      if (m_act == M_CSR) begin
        f = 8'b1101_1100; ew = m_pc; cw = m_cause;
      end else if (m_act == M_VEC) begin
        f = 8'b1010_0000; rp = {mtvec[31:2], 2'b00};
      end else if (m_act == M_RET) begin
        f = 8'b1010_0010; rp = mepc;
      end else if (m_hand) begin
        f = 8'b0000_0001;
      end
    end
    return {f, rp, ew, cw};
  endfunction

  // One rising edge: advance the model on the same inputs the DUT sees,
  // then return at the falling edge where outputs are compared.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_act = M_NONE; m_hand = 0; m_pc = '0; m_cause = '0;
    end else if (m_act == M_CSR) begin
      m_act = M_VEC;
    end else if (m_act == M_VEC) begin
      m_act = M_NONE; m_hand = 1;
    end else if (m_act == M_RET) begin
      m_act = M_NONE;
    end else if (m_hand) begin
      if (mret_e) begin m_hand = 0; m_act = M_RET; end
    end else if ((ext_irq | tmr_irq) && mie_g && valid_m) begin
      m_act   = M_CSR;
      m_pc    = pc_m;
      m_cause = tmr_irq ? 32'h8000_0007 : 32'h8000_000B;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    ext_irq = 0; tmr_irq = 0; mret_e = 0; valid_m = 1; mie_g = 1; rst = 0;
  endtask

  task automatic test_reset();
    quiet(); rst = 1; pc_m = 32'h1234; mtvec = 32'h200; mepc = 32'h55;
    tick(); tick();
    total++;
    if (obs_vec() !== 104'h0) begin
      bad++; $display("FAIL reset_outputs: got %h expected 0", obs_vec());
    end
    rst = 0;
  endtask

  task automatic test_timer_take();
    logic [103:0] e;
    quiet(); tmr_irq = 1; pc_m = 32'h100; mtvec = 32'h200;
    tick();
    total++;
    if (mepc_wd !== 32'h100 || mcause_wd !== 32'h8000_0007 || !mepc_we || !mcause_we) begin
      bad++; $display("FAIL tmr_take_csr: got we=%b/%b wd=%h/%h expected 1/1 00000100/80000007",
                      mepc_we, mcause_we, mepc_wd, mcause_wd);
    end
    tmr_irq = 0; pc_m = 32'h444;
    tick();
    total++;
    if (redir_pc !== 32'h200 || !redir_v || !int_flush) begin
      bad++; $display("FAIL tmr_redirect: got v=%b pc=%h expected 1 00000200", redir_v, redir_pc);
    end
    tick(); e = exp_vec();
    total++;
    if (obs_vec() !== e) begin
      bad++; $display("FAIL enter_handler: got %h expected %h", obs_vec(), e);
    end
  endtask

  task automatic test_no_nesting();
    logic [103:0] e;
    ext_irq = 1; tmr_irq = 1;
    for (int i = 0; i < 3; i++) begin
      pc_m = $urandom; tick(); e = exp_vec();
      total++;
      if (obs_vec() !== e || int_flush || mepc_we || mcause_we || !in_handler) begin
        bad++; $display("FAIL no_nesting[%0d]: got %h expected %h", i, obs_vec(), e);
      end
    end
    ext_irq = 0; tmr_irq = 0;
  endtask

  task automatic test_mret();
    mret_e = 1; mepc = 32'h104;
    tick(); mret_e = 0;
    total++;
    if (redir_pc !== 32'h104 || !mie_set || !redir_v || !int_flush || in_handler) begin
      bad++; $display("FAIL mret_return: got pc=%h set=%b v=%b h=%b expected 00000104 1 1 0",
                      redir_pc, mie_set, redir_v, in_handler);
    end
    tick();
    total++;
    if (obs_vec() !== 104'h0) begin
      bad++; $display("FAIL after_return_idle: got %h expected 0", obs_vec());
    end
  endtask

  task automatic test_both_irq();
    logic [103:0] e;
    quiet(); ext_irq = 1; tmr_irq = 1; pc_m = 32'h3000;
    tick(); ext_irq = 0; tmr_irq = 0; e = exp_vec();
    total++;
    if (mcause_wd !== 32'h8000_0007 || obs_vec() !== e) begin
      bad++; $display("FAIL both_irq_cause: got %h expected 80000007", mcause_wd);
    end
    tick(); tick(); mret_e = 1; tick(); mret_e = 0; tick();
    total++;
    if (obs_vec() !== 104'h0) begin
      bad++; $display("FAIL both_irq_exit: got %h expected 0", obs_vec());
    end
  endtask

  task automatic test_bubble();
    logic [103:0] e;
    quiet(); ext_irq = 1; valid_m = 0; pc_m = 32'h880;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (int_flush || mepc_we || mcause_we) begin
        bad++; $display("FAIL bubble_wait[%0d]: got flush=%b we=%b expected 0 0", i, int_flush, mepc_we);
      end
    end
    valid_m = 1; pc_m = 32'h884;
    tick(); e = exp_vec();
    total++;
    if (obs_vec() !== e || mepc_wd !== 32'h884 || mcause_wd !== 32'h8000_000B) begin
      bad++; $display("FAIL bubble_take: got %h expected %h", obs_vec(), e);
    end
    ext_irq = 0;
    tick(); tick(); mret_e = 1; tick(); mret_e = 0; tick();
  endtask

  task automatic test_mret_idle();
    quiet(); mret_e = 1; mepc = 32'h7777;
    tick(); tick();
    total++;
    if (obs_vec() !== 104'h0) begin
      bad++; $display("FAIL mret_in_idle: got %h expected 0", obs_vec());
    end
    mret_e = 0;
  endtask

  task automatic test_pend_in_return();
    logic [103:0] e;
    quiet(); ext_irq = 1; pc_m = 32'h40;
    tick(); tick(); tick();
    mret_e = 1; tick(); mret_e = 0;
    tick(); e = exp_vec();
    total++;
    if (obs_vec() !== 104'h0 || e !== 104'h0) begin
      bad++; $display("FAIL return_not_evaluated: got %h expected 0", obs_vec());
    end
    tick(); e = exp_vec();
    total++;
    if (!mepc_we || obs_vec() !== e) begin
      bad++; $display("FAIL retake_after_idle: got %h expected %h", obs_vec(), e);
    end
    ext_irq = 0;
  endtask

  task automatic test_rst_mid();
    quiet(); rst = 1; tick(); rst = 0;
    tmr_irq = 1; pc_m = 32'h900;
    tick(); tmr_irq = 0;
    rst = 1; #1;
    total++;
    if (mepc_we || mcause_we || int_flush || mie_clr) begin
      bad++; $display("FAIL rst_in_take: got we=%b/%b flush=%b expected 0 0 0", mepc_we, mcause_we, int_flush);
    end
    tick(); rst = 0;
    tmr_irq = 1; tick(); tmr_irq = 0; tick();
    total++;
    if (!redir_v) begin
      bad++; $display("FAIL reach_redir: got redir_v=%b expected 1", redir_v);
    end
    rst = 1; tick();
    total++;
    if (obs_vec() !== 104'h0) begin
      bad++; $display("FAIL rst_in_redir: got %h expected 0", obs_vec());
    end
    rst = 0; tick();
    total++;
    if (obs_vec() !== 104'h0) begin
      bad++; $display("FAIL idle_after_rst: got %h expected 0", obs_vec());
    end
  endtask

  task automatic test_random();
    logic [103:0] e;
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 49) == 0);
      ext_irq = ($urandom_range(0, 5) == 0);
      tmr_irq = ($urandom_range(0, 7) == 0);
      mie_g   = ($urandom_range(0, 3) != 0);
      valid_m = ($urandom_range(0, 3) != 0);
      mret_e  = ($urandom_range(0, 3) == 0);
      pc_m    = $urandom;
      mtvec   = $urandom;
      mepc    = $urandom;
      tick(); e = exp_vec();
      total++;
      if (obs_vec() !== e) begin
        bad++; $display("FAIL random[%0d]: got %h expected %h", i, obs_vec(), e);
      end
    end
    quiet();
  endtask

  initial begin
    m_act = M_NONE; m_hand = 0; m_pc = '0; m_cause = '0;
    quiet(); rst = 1; pc_m = '0; mtvec = '0; mepc = '0;
    @(negedge clk);
    test_reset();
    test_timer_take();
    test_no_nesting();
    test_mret();
    test_both_irq();
    test_bubble();
    test_mret_idle();
    test_pend_in_return();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have: clk  in  1  clock; all state changes on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: ext_irq  in  1  external interrupt request, level.
REQ-004 SHALL have: tmr_irq  in  1  timer interrupt request, level.
REQ-005 SHALL have: mie_g  in  1  mstatus.MIE global enable.
REQ-006 SHALL have: valid_m  in  1  a real (non-bubble) instruction occupies the memory stage.
REQ-007 SHALL have: pc_m  in  32  PC of the memory-stage instruction.
REQ-008 SHALL have: mret_e  in  1  MRET in the execute stage.
REQ-009 SHALL have: mtvec  in  32  trap vector base, direct mode.
REQ-010 SHALL have: mepc  in  32  current mepc CSR value.
REQ-011 SHALL have: int_flush  out  1  flush to all pipeline registers.
REQ-012 SHALL have: stall_f  out  1  hold the fetch PC.
REQ-013 SHALL have: redir_v  out  1  PC redirect valid.
REQ-014 SHALL have: redir_pc  out  32  redirect target.
REQ-015 SHALL have: mepc_we / mepc_wd  out  1/32  mepc write.
REQ-016 SHALL have: mcause_we / mcause_wd  out  1/32  mcause write.
REQ-017 SHALL have: mie_clr / mie_set  out  1/1  clear or restore mstatus.MIE.
REQ-018 SHALL have: in_handler  out  1  trap handler executing.

Function
REQ-019 SHALL implement FSM states IDLE, TAKE, REDIR, HANDLER, RETURN, all outputs registered-state decoded (Moore).
REQ-020 IDLE: pend = (ext_irq | tmr_irq) & mie_g & valid_m; SHALL move to TAKE on the cycle after pend=1.
REQ-021 SHALL sample and hold pc_m and cause at the IDLE->TAKE edge.
REQ-022 Cause priority: timer over external; timer -> mcause 0x80000007, external -> 0x8000000B.
REQ-023 TAKE, 1 cycle: int_flush=1, stall_f=1, mepc_we=1 (wd = held pc_m), mcause_we=1, mie_clr=1.
REQ-024 REDIR, 1 cycle: int_flush=1, redir_v=1, redir_pc = {mtvec[31:2],2'b00}.
REQ-025 HANDLER: in_handler=1, other outputs 0; interrupts SHALL NOT nest.
REQ-026 HANDLER with mret_e=1 SHALL move to RETURN.
REQ-027 RETURN, 1 cycle: int_flush=1, redir_v=1, redir_pc = mepc input, mie_set=1; next state IDLE.
REQ-028 Total take latency: pend at cycle N -> CSR writes at N+1 -> redirect at N+2 -> HANDLER at N+3.
REQ-029 pend with valid_m=0 (bubble) SHALL wait in IDLE; no trap taken.
REQ-030 mret_e in IDLE SHALL be ignored.
REQ-031 Request dropping during TAKE/REDIR SHALL NOT abort the sequence.
REQ-032 Request still pending in RETURN SHALL NOT be evaluated until IDLE, earliest one cycle later.
REQ-033 All outputs other than those listed per state SHALL be 0.

Reset
REQ-034 rst=1 SHALL force IDLE, clear held pc/cause, drive every output to 0, including redir_pc and *_wd.
REQ-035 rst mid-sequence (any state) SHALL abandon it with no CSR write in that cycle.

Structure
REQ-036 Package trap_pkg SHALL hold the state enum and the constants CAUSE_TMR=0x80000007 and CAUSE_EXT=0x8000000B.
REQ-037 A sub-module irq_priority (combinational cause encoder) SHALL be used; the FSM stays in trap_controller.

Verification
REQ-038 Verification SHALL cover: tmr_irq=1, mie_g=1, valid_m=1, pc_m=0x100, mtvec=0x200 -> mepc_wd=0x100, mcause_wd=0x80000007 at N+1, redir_pc=0x200 at N+2.
REQ-039 Verification SHALL cover: ext_irq and tmr_irq together -> mcause_wd=0x80000007.
REQ-040 Verification SHALL cover: ext_irq=1, valid_m=0 for 3 cycles, then valid_m=1 -> TAKE only after valid_m rises.
REQ-041 Verification SHALL cover: in HANDLER, mret_e=1, mepc=0x104 -> RETURN with redir_pc=0x104, mie_set=1, then IDLE.
REQ-042 Verification SHALL cover: ext_irq in HANDLER -> no flush, no CSR write (no nesting).
REQ-043 Verification SHALL cover: rst during REDIR -> next cycle IDLE, all outputs 0.
